// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - shared types and helpers for the operand-hazard scoreboard
package sb_pkg;

    // Wide enough for age/lat with NSTAGE up to 15.
    localparam int ENT_W       = 4;
    localparam int SEL_REGFILE = 0;

    typedef struct packed {
        logic             pend;
        logic [ENT_W-1:0] age;
        logic [ENT_W-1:0] lat;
        logic             is_long;
    } sb_entry_t;

    function automatic int sel_long(input int nstage);
        return nstage + 1;
    endfunction

endpackage

// File: rtl/sb_read_port.sv
// rtl/sb_read_port.sv - one operand lookup: ready and forward-select for a read port
module sb_read_port
    import sb_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int NSTAGE = 3,
    parameter int SEL_W  = 3
) (
    input  logic             need_i,
    input  logic [4:0]       addr_i,
    input  sb_entry_t        table_i [NREG],
    input  logic             long_done_i,
    input  logic [4:0]       long_waddr_i,
    output logic             ready_o,
    output logic [SEL_W-1:0] sel_o
);

    sb_entry_t ent;
    assign ent = table_i[addr_i];

    always_comb begin
        ready_o = 1'b1;
        sel_o   = SEL_W'(SEL_REGFILE);
        if (!need_i || addr_i == 5'd0 || !ent.pend) begin
            ready_o = 1'b1;
        end else if (ent.is_long) begin
            // A long result is only visible on the completion bus in its done cycle.
            if (long_done_i && long_waddr_i == addr_i) begin
                sel_o = SEL_W'(sel_long(NSTAGE));
            end else begin
                ready_o = 1'b0;
            end
        end else if (ent.age < ent.lat) begin
            ready_o = 1'b0;
        end else begin
            sel_o = SEL_W'(ent.age);
        end
    end

endmodule

// File: rtl/id_scoreboard.sv
// rtl/id_scoreboard.sv - per-register hazard table with ageing, flush and stall reduction
module id_scoreboard
    import sb_pkg::*;
#(
    parameter int NREG      = 32,
    parameter int NREAD     = 2,
    parameter int NSTAGE    = 3,
    parameter int LAT_W     = 2,
    parameter int FLUSH_AGE = 2,
    localparam int SEL_W    = $clog2(NSTAGE + 2)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   advance_i,
    input  logic                   issue_valid_i,
    input  logic                   issue_we_i,
    input  logic [4:0]             issue_waddr_i,
    input  logic [LAT_W-1:0]       issue_lat_i,
    input  logic                   issue_long_i,
    input  logic                   long_done_i,
    input  logic [4:0]             long_waddr_i,
    input  logic                   flush_i,
    input  logic [NREAD-1:0]       rd_need_i,
    input  logic [NREAD*5-1:0]     rd_addr_i,
    output logic [NREAD-1:0]       rd_ready_o,
    output logic [NREAD*SEL_W-1:0] rd_sel_o,
    output logic                   stall_o,
    output logic [NREG-1:0]        busy_o
);

    sb_entry_t        tbl_q [NREG];
    sb_entry_t        tbl_d [NREG];
    logic [NREAD-1:0] port_rdy;
    logic             fire;
    logic             waw_long;
    logic [ENT_W-1:0] lat_eff;

    assign fire    = issue_valid_i & ~stall_o & advance_i & ~flush_i;
    assign lat_eff = (issue_lat_i == '0) ? ENT_W'(1) : ENT_W'(issue_lat_i);

    // Later statements win: ageing, then long completion, then issue, then flush.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            tbl_d[r] = tbl_q[r];
            if (advance_i && tbl_q[r].pend && !tbl_q[r].is_long) begin
                if (tbl_q[r].age == ENT_W'(NSTAGE)) begin
                    tbl_d[r] = '0;
                end else begin
                    tbl_d[r].age = tbl_q[r].age + 1'b1;
                end
            end
            if (long_done_i && long_waddr_i == 5'(r) && tbl_q[r].is_long) begin
                tbl_d[r] = '0;
            end
            if (fire && issue_we_i && issue_waddr_i == 5'(r)) begin
                tbl_d[r].pend    = 1'b1;
                tbl_d[r].age     = '0;
                tbl_d[r].lat     = lat_eff;
                tbl_d[r].is_long = issue_long_i;
            end
            if (flush_i && tbl_q[r].pend &&
                (tbl_q[r].is_long || tbl_q[r].age < ENT_W'(FLUSH_AGE))) begin
                tbl_d[r] = '0;
            end
            if (r == 0) begin
                tbl_d[r] = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREG; r++) begin
                tbl_q[r] <= '0;
            end
        end else begin
            tbl_q <= tbl_d;
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            busy_o[r] = tbl_q[r].pend;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_port
        sb_read_port #(
            .NREG   (NREG),
            .NSTAGE (NSTAGE),
            .SEL_W  (SEL_W)
        ) u_port (
            .need_i       (rd_need_i[i]),
            .addr_i       (rd_addr_i[i*5 +: 5]),
            .table_i      (tbl_q),
            .long_done_i  (long_done_i),
            .long_waddr_i (long_waddr_i),
            .ready_o      (port_rdy[i]),
            .sel_o        (rd_sel_o[i*SEL_W +: SEL_W])
        );
    end

    assign rd_ready_o = port_rdy;
    assign waw_long   = issue_we_i && issue_waddr_i != 5'd0 &&
                        tbl_q[issue_waddr_i].pend && tbl_q[issue_waddr_i].is_long;
    assign stall_o    = issue_valid_i & ((|(~port_rdy)) | waw_long);

endmodule

// File: tb/tb_id_scoreboard.sv
// tb/tb_id_scoreboard.sv - directed scoreboard bench for id_scoreboard
module tb_id_scoreboard;

    logic        clk = 1'b0;
    logic        rst_i, advance_i, issue_valid_i, issue_we_i, issue_long_i;
    logic [4:0]  issue_waddr_i, long_waddr_i;
    logic [1:0]  issue_lat_i;
    logic        long_done_i, flush_i;
    logic [1:0]  rd_need_i;
    logic [9:0]  rd_addr_i;
    logic [1:0]  rd_ready_o;
    logic [5:0]  rd_sel_o;
    logic        stall_o;
    logic [31:0] busy_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [1:0]  rdy;
        logic [5:0]  sel;
        logic        stall;
        logic [31:0] busy;
    } exp_t;

    exp_t exp_q[$];

    id_scoreboard dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .advance_i     (advance_i),
        .issue_valid_i (issue_valid_i),
        .issue_we_i    (issue_we_i),
        .issue_waddr_i (issue_waddr_i),
        .issue_lat_i   (issue_lat_i),
        .issue_long_i  (issue_long_i),
        .long_done_i   (long_done_i),
        .long_waddr_i  (long_waddr_i),
        .flush_i       (flush_i),
        .rd_need_i     (rd_need_i),
        .rd_addr_i     (rd_addr_i),
        .rd_ready_o    (rd_ready_o),
        .rd_sel_o      (rd_sel_o),
        .stall_o       (stall_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bit_of(input int r);
        return 32'(1) << r;
    endfunction

    task automatic expect_out(input string n, input logic [1:0] rdy, input int s0, input int s1,
                              input logic st, input logic [31:0] busy);
        exp_t e;
        e.name  = n;
        e.rdy   = rdy;
        e.sel   = {3'(s1), 3'(s0)};
        e.stall = st;
        e.busy  = busy;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid_i = 0; issue_we_i = 0; issue_waddr_i = 0; issue_lat_i = 0;
        issue_long_i = 0; long_done_i = 0; long_waddr_i = 0; flush_i = 0;
        rd_need_i = 0; rd_addr_i = 0;
    endtask

    task automatic iss(input int r, input int lat, input logic lng);
        issue_valid_i = 1; issue_we_i = 1; issue_waddr_i = 5'(r);
        issue_lat_i = 2'(lat); issue_long_i = lng;
    endtask

    task automatic rd(input int port, input int r, input logic need);
        rd_addr_i[port*5 +: 5] = 5'(r);
        rd_need_i[port] = need;
    endtask

    // Monitor: compares every queued expectation against the outputs mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (rd_ready_o !== e.rdy || rd_sel_o !== e.sel ||
                    stall_o !== e.stall || busy_o !== e.busy) begin
                    errors++;
                    $display("FAIL %s: got ready=%b sel=%h stall=%b busy=%h, want ready=%b sel=%h stall=%b busy=%h",
                             e.name, rd_ready_o, rd_sel_o, stall_o, busy_o,
                             e.rdy, e.sel, e.stall, e.busy);
                end
            end
        end
    end

    initial begin
        idle();
        rst_i = 1; advance_i = 1;
        #1;
        step();
        expect_out("reset", 2'b11, 0, 0, 0, 32'h0);
        step();
        rst_i = 0;

        // ALU back-to-back forwarding through EX, MEM, WB
        iss(5, 1, 0);
        expect_out("alu_issue", 2'b11, 0, 0, 0, 32'h0);
        step();
        idle(); rd(0, 5, 1);
        expect_out("alu_age0", 2'b10, 0, 0, 0, bit_of(5));
        step();
        expect_out("alu_sel1", 2'b11, 1, 0, 0, bit_of(5));
        step();
        expect_out("alu_sel2", 2'b11, 2, 0, 0, bit_of(5));
        step();
        expect_out("alu_sel3", 2'b11, 3, 0, 0, bit_of(5));
        step();
        expect_out("alu_done", 2'b11, 0, 0, 0, 32'h0);
        step();

        // Load-use
        idle(); iss(8, 2, 0);
        step();
        idle(); issue_valid_i = 1; rd(0, 8, 1);
        expect_out("lu_age0", 2'b10, 0, 0, 1, bit_of(8));
        step();
        expect_out("lu_age1", 2'b10, 0, 0, 1, bit_of(8));
        step();
        expect_out("lu_ready", 2'b11, 2, 0, 0, bit_of(8));
        step();

        // Freeze with advance low
        idle(); advance_i = 0; rd(1, 8, 1);
        for (int k = 0; k < 5; k++) begin
            expect_out("freeze", 2'b11, 0, 3, 0, bit_of(8));
            step();
        end
        advance_i = 1;
        expect_out("frz_last", 2'b11, 0, 3, 0, bit_of(8));
        step();
        expect_out("post_freeze", 2'b11, 0, 0, 0, 32'h0);
        step();

        // Long op, WAW on pending long, completion bus
        idle(); iss(4, 1, 1);
        step();
        idle(); issue_valid_i = 1; rd(0, 4, 1);
        for (int k = 0; k < 3; k++) begin
            expect_out("long_wait", 2'b10, 0, 0, 1, bit_of(4));
            step();
        end
        rd_need_i = 0; issue_we_i = 1; issue_waddr_i = 5'd4;
        expect_out("long_waw", 2'b11, 0, 0, 1, bit_of(4));
        step();
        issue_we_i = 0; rd(0, 4, 1); long_done_i = 1; long_waddr_i = 5'd4;
        expect_out("long_done", 2'b11, 4, 0, 0, bit_of(4));
        step();
        long_done_i = 0;
        expect_out("long_after", 2'b11, 0, 0, 0, 32'h0);
        step();

        // Flush: ages 0,1,2 plus a long entry
        idle(); iss(13, 1, 1);
        step();
        iss(10, 1, 0);
        step();
        iss(11, 1, 0);
        step();
        iss(12, 1, 0);
        step();
        idle(); iss(14, 1, 0); flush_i = 1;
        expect_out("fl_pre", 2'b11, 0, 0, 0, bit_of(10) | bit_of(11) | bit_of(12) | bit_of(13));
        step();
        idle(); rd(1, 10, 1);
        expect_out("fl_post", 2'b11, 0, 3, 0, bit_of(10));
        step();
        expect_out("fl_clear", 2'b11, 0, 0, 0, 32'h0);
        step();

        // Register 0 and unneeded port
        idle(); iss(0, 1, 0);
        step();
        iss(20, 3, 0);
        step();
        idle(); issue_valid_i = 1; rd(0, 0, 1); rd(1, 20, 0);
        expect_out("r0_noneed", 2'b11, 0, 0, 0, bit_of(20));
        step();
        rd(1, 20, 1);
        expect_out("need_port1", 2'b01, 0, 0, 1, bit_of(20));
        step();

        // Reset mid-stream
        rst_i = 1;
        step();
        expect_out("rst_mid", 2'b11, 0, 0, 0, 32'h0);
        step();
        rst_i = 0; idle();
        step();
        step();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
